flags_cond_checker: RTL
=======================

// Module: flags_cond_checker
// PURPOSE
//  Reader side of the flags register. Takes a stream of ARM condition codes,
//    evaluates each one against the stored NZCV flags, and returns an execute/skip verdict.
//  Sits between the decode stage and execute/writeback. Consumes the flags register
//    output word and its active-low write enable.
//  Enforces read-after-write ordering: a flag write in the cycle a condition is accepted
//    is seen by that condition.
// PARAMETERS
//  TAG_W    4   width of the opaque tag carried from input to output
//  COUNT_W  16  width of the saturating pass/fail statistics counters
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        synchronous reset, active-high
//  flags_i      in   32       flags register word; N=[31] Z=[30] C=[29] V=[28]
//  flag_we_n_i  in   1        flags register write enable, active-low (write at this edge)
//  in_valid_i   in   1        condition request valid
//  in_ready_o   out  1        block can accept a request this cycle
//  cond_i       in   4        ARM condition field
//  tag_i        in   TAG_W    request tag
//  out_valid_o  out  1        verdict valid
//  out_ready_i  in   1        consumer accepts the verdict
//  exec_o       out  1        1 = condition passed
//  nzcv_o       out  4        flags used for the verdict, {N,Z,C,V}
//  tag_o        out  TAG_W    tag of the request
//  pass_cnt_o   out  COUNT_W  verdicts delivered with exec_o=1, saturating
//  fail_cnt_o   out  COUNT_W  verdicts delivered with exec_o=0, saturating
// BEHAVIOUR
//  Reset
//    Synchronous, dominates all other inputs. Any held request or verdict is dropped.
//    State=IDLE. out_valid_o=0, exec_o=0, nzcv_o=0, tag_o=0, both counters=0.
//  Handshake
//    Input transfer on in_valid_i & in_ready_o. Output transfer on out_valid_o & out_ready_i.
//    Once out_valid_o=1, it and exec_o/nzcv_o/tag_o hold stable until the transfer.
//  States
//    IDLE: no verdict held.
//    WAIT: request captured, flags write in flight.
//    OUT:  verdict held.
//  in_ready_o
//    = (state==IDLE) | (state==OUT & out_ready_i). Always 0 in WAIT.
//  Accept in cycle T with flag_we_n_i=1
//    Evaluate cond_i against flags_i[31:28] at T.
//    Register the result; out_valid_o=1 at T+1 (state OUT). Latency 1.
//  Accept in cycle T with flag_we_n_i=0
//    Capture cond/tag and go to WAIT. flags_i is stale at T.
//    At T+1, evaluate against flags_i (now updated); out_valid_o=1 at T+2. Latency 2.
//    A write at T+1 is NOT seen by this request.
//  Back-to-back operation
//    OUT with out_ready_i=1 and a new accept in the same cycle: the new verdict replaces
//    the old one, with no bubble (throughput 1/cycle when no hazard).
//    The same applies when the new accept hits a hazard: go to WAIT, out_valid_o=0 for one cycle.
//    OUT with out_ready_i=1 and no accept: go to IDLE.
//  Condition table
//    0 EQ Z            1 NE !Z
//    2 CS C            3 CC !C
//    4 MI N            5 PL !N
//    6 VS V            7 VC !V
//    8 HI C&!Z         9 LS !C|Z
//    A GE N==V         B LT N!=V
//    C GT !Z&(N==V)    D LE Z|(N!=V)
//    E AL 1            F NV 0 (reserved; treated as never)
//  Counters
//    Increment once per output transfer: pass if exec_o=1, else fail.
//    Hold at 2^COUNT_W-1; no wrap.
//  flags_i bits [27:0] are ignored.
// STRUCTURE
//  Shared package flags_pkg: N/Z/C/V bit positions, the 16 COND_* 4-bit constants,
//    and state encodings IDLE/WAIT/OUT.
//  Sub-module cond_eval: purely combinational (cond[3:0], nzcv[3:0]) -> pass. Unit-testable alone.
//  Top level holds the FSM, the output register and the two counters.
// TESTING
//  1. flags_i=32'h4000_0000 (Z=1), we_n=1, cond=0 (EQ), tag=3
//       -> out_valid_o at T+1, exec_o=1, nzcv_o=4'b0100, tag_o=3, pass_cnt_o=1.
//  2. flags_i=0, we_n=0 in the accept cycle, flags_i becomes 32'h4000_0000 at T+1, cond=0
//       -> in_ready_o=0 at T+1, out_valid_o at T+2, exec_o=1.
//  3. Sweep all 16 conds x 16 NZCV values through cond_eval vs a table model
//       -> 256/256 match; cond F always 0.
//  4. Hold out_ready_i=0 for 5 cycles with a verdict pending
//       -> outputs stable, in_ready_o=0, counters unchanged.
//     Then out_ready_i=1 with in_valid_i=1 -> new verdict next cycle, no bubble.
//  5. COUNT_W=2; deliver 5 passing verdicts -> pass_cnt_o saturates at 3.
//  6. Assert rst while in WAIT and while in OUT
//       -> next cycle out_valid_o=0, counters=0, in_ready_o=1.

Source files
------------

// File: rtl/flags_cond_checker_pkg.sv
// Shared definitions for the flags-register reader: flag bit positions,
// ARM condition codes and the checker FSM state type.
package flags_pkg;

  localparam int N_BIT = 31;
  localparam int Z_BIT = 30;
  localparam int C_BIT = 29;
  localparam int V_BIT = 28;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/flags_cond_checker_if.sv
// Request/verdict stream between decode and execute for the condition checker.
interface flags_cond_checker_if #(
  parameter int TAG_W = 4
) ();
  logic             in_valid_i;
  logic             in_ready_o;
  logic [3:0]       cond_i;
  logic [TAG_W-1:0] tag_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             exec_o;
  logic [3:0]       nzcv_o;
  logic [TAG_W-1:0] tag_o;

  modport master (
    output in_valid_i, cond_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, exec_o, nzcv_o, tag_o
  );

  modport slave (
    input  in_valid_i, cond_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, exec_o, nzcv_o, tag_o
  );
endinterface

// File: rtl/flags_cond_checker_cond_eval.sv
// Combinational ARM condition evaluation against an {N,Z,C,V} nibble.
module cond_eval
  import flags_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);
  logic n, z, c, v;

  assign n = nzcv[3];
  assign z = nzcv[2];
  assign c = nzcv[1];
  assign v = nzcv[0];

  // Condition table lookup
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/flags_cond_checker.sv
// Condition checker: accepts condition requests, evaluates them against the
// flags register with read-after-write ordering, and streams out verdicts
// while keeping saturating pass/fail statistics.
module flags_cond_checker
  import flags_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int COUNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          flags_i,
  input  logic                 flag_we_n_i,
  flags_cond_checker_if.slave  bus,
  output logic [COUNT_W-1:0]   pass_cnt_o,
  output logic [COUNT_W-1:0]   fail_cnt_o
);
  state_t           state, state_next;
  logic [3:0]       held_cond;
  logic [TAG_W-1:0] held_tag;
  logic             exec_r;
  logic [3:0]       nzcv_r;
  logic [TAG_W-1:0] tag_r;
  logic             in_ready, accept, out_fire;
  logic             load_out, load_hold;
  logic [3:0]       eval_cond;
  logic [TAG_W-1:0] eval_tag;
  logic [3:0]       flag_nzcv;
  logic             pass;
  logic             flags_unused;

  assign flag_nzcv    = {flags_i[N_BIT], flags_i[Z_BIT], flags_i[C_BIT], flags_i[V_BIT]};
  assign flags_unused = ^flags_i[27:0];

  // One evaluator serves both paths: WAIT re-evaluates the held request
  // against the freshly written flags, otherwise the incoming request is used.
  cond_eval u_cond_eval (
    .cond (eval_cond),
    .nzcv (flag_nzcv),
    .pass (pass)
  );

  // Next-state, handshake and load-enable decode
  always_comb begin
    state_next = state;
    load_out   = 1'b0;
    load_hold  = 1'b0;
    eval_cond  = bus.cond_i;
    eval_tag   = bus.tag_i;
    in_ready   = (state == IDLE) || ((state == OUT) && bus.out_ready_i);
    accept     = bus.in_valid_i && in_ready;
    out_fire   = (state == OUT) && bus.out_ready_i;
    case (state)
      WAIT: begin
        eval_cond  = held_cond;
        eval_tag   = held_tag;
        load_out   = 1'b1;
        state_next = OUT;
      end
      default: begin
        if (accept) begin
          if (flag_we_n_i) begin
            load_out   = 1'b1;
            state_next = OUT;
          end else begin
            load_hold  = 1'b1;
            state_next = WAIT;
          end
        end else if (out_fire || state == IDLE) begin
          state_next = IDLE;
        end
      end
    endcase
  end

  // State, held request and verdict registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      held_cond <= '0;
      held_tag  <= '0;
      exec_r    <= 1'b0;
      nzcv_r    <= '0;
      tag_r     <= '0;
    end else begin
      state <= state_next;
      if (load_hold) begin
        held_cond <= bus.cond_i;
        held_tag  <= bus.tag_i;
      end
      if (load_out) begin
        exec_r <= pass;
        nzcv_r <= flag_nzcv;
        tag_r  <= eval_tag;
      end
    end
  end

  // Saturating statistics, stepped once per delivered verdict
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_cnt_o <= '0;
      fail_cnt_o <= '0;
    end else if (out_fire) begin
      if (exec_r) begin
        if (pass_cnt_o != '1) pass_cnt_o <= pass_cnt_o + 1'b1;
      end else begin
        if (fail_cnt_o != '1) fail_cnt_o <= fail_cnt_o + 1'b1;
      end
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = (state == OUT);
  assign bus.exec_o      = exec_r;
  assign bus.nzcv_o      = nzcv_r;
  assign bus.tag_o       = tag_r;
endmodule
